pixel_dispatcher: RTL and testbench

PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

---
 rtl/pixel_dispatcher_pkg.sv | 26 ++
 rtl/pixel_dispatcher_coord.sv | 62 ++++++
 rtl/pixel_dispatcher.sv | 131 +++++++++++++
 tb/tb_pixel_dispatcher.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_dispatcher_pkg.sv
// Shared types and defaults for the pixel dispatcher and its coordinate stepper.
package pixel_dispatcher_pkg;

  localparam int unsigned WORD_LENGTH_DEF = 64;
  localparam int unsigned FRAC_DEF        = 60;
  localparam int unsigned H_RES_DEF       = 640;
  localparam int unsigned V_RES_DEF       = 480;
  localparam int unsigned DEPTH_W         = 10;
  localparam int unsigned COORD_W         = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT
  } disp_state_t;

  typedef struct packed {
    logic [DEPTH_W-1:0] depth;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               eol;
  } pixel_t;

endpackage

// File: rtl/pixel_dispatcher_coord.sv
// Raster counters and complex-plane coordinate accumulation for the dispatcher.
module coord_stepper
  import pixel_dispatcher_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int unsigned H_RES       = H_RES_DEF,
  parameter int unsigned V_RES       = V_RES_DEF
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   advance,
  input  logic [WORD_LENGTH-1:0] re_origin,
  input  logic [WORD_LENGTH-1:0] im_origin,
  input  logic [WORD_LENGTH-1:0] step,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic [WORD_LENGTH-1:0] re_c,
  output logic [WORD_LENGTH-1:0] im_c,
  output logic                   last_x_c,
  output logic                   last_y_c
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  logic [WORD_LENGTH-1:0] re_org_q;
  logic [WORD_LENGTH-1:0] step_q;

  assign last_x_c = (x == X_LAST);
  assign last_y_c = (y == Y_LAST);

  // Imaginary axis decreases downward; arithmetic wraps in two's complement.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      re_c     <= '0;
      im_c     <= '0;
      re_org_q <= '0;
      step_q   <= '0;
    end else if (load) begin
      x        <= '0;
      y        <= '0;
      re_c     <= re_origin;
      im_c     <= im_origin;
      re_org_q <= re_origin;
      step_q   <= step;
    end else if (advance) begin
      if (!last_x_c) begin
        x    <= x + COORD_W'(1);
        re_c <= re_c + step_q;
      end else if (!last_y_c) begin
        x    <= '0;
        y    <= y + COORD_W'(1);
        re_c <= re_org_q;
        im_c <= im_c - step_q;
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Walks a frame in raster order, issuing one depth calculation per pixel and
// presenting each result on a valid/ready stream.
module pixel_dispatcher
  import pixel_dispatcher_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int unsigned FRAC        = FRAC_DEF,
  parameter int unsigned H_RES       = H_RES_DEF,
  parameter int unsigned V_RES       = V_RES_DEF
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [WORD_LENGTH-1:0] re_origin,
  input  logic [WORD_LENGTH-1:0] im_origin,
  input  logic [WORD_LENGTH-1:0] step,
  output logic                   calc_start,
  output logic [WORD_LENGTH-1:0] re_c,
  output logic [WORD_LENGTH-1:0] im_c,
  input  logic                   calc_done,
  input  logic [DEPTH_W-1:0]     calc_depth,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEPTH_W-1:0]     out_depth,
  output logic [COORD_W-1:0]     out_x,
  output logic [COORD_W-1:0]     out_y,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   busy,
  output logic                   frame_done
);

  if (FRAC >= WORD_LENGTH) begin : g_frac_check
    $error("FRAC must leave at least one integer bit in WORD_LENGTH");
  end

  disp_state_t        state;
  pixel_t             pix_q;
  logic               calc_done_q;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               last_x_c;
  logic               last_y_c;
  logic               load_c;
  logic               advance_c;
  logic               done_rise_c;

  // A frame_done pulse marks the first IDLE cycle; a start in that cycle is dropped.
  assign load_c      = (state == ST_IDLE) && frame_start && !frame_done;
  assign advance_c   = (state == ST_EMIT) && out_valid && out_ready;
  assign done_rise_c = calc_done && !calc_done_q;

  coord_stepper #(
    .WORD_LENGTH(WORD_LENGTH),
    .H_RES      (H_RES),
    .V_RES      (V_RES)
  ) u_coord (
    .sysclk   (sysclk),
    .reset    (reset),
    .load     (load_c),
    .advance  (advance_c),
    .re_origin(re_origin),
    .im_origin(im_origin),
    .step     (step),
    .x        (x),
    .y        (y),
    .re_c     (re_c),
    .im_c     (im_c),
    .last_x_c (last_x_c),
    .last_y_c (last_y_c)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      calc_start  <= 1'b0;
      out_valid   <= 1'b0;
      pix_q       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      calc_done_q <= 1'b0;
    end else begin
      calc_done_q <= calc_done;
      calc_start  <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_c) begin
            state      <= ST_ISSUE;
            calc_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          // Only a fresh rising edge counts; a level left over from the last pixel is stale.
          if (done_rise_c) begin
            pix_q.depth <= calc_depth;
            pix_q.x     <= x;
            pix_q.y     <= y;
            pix_q.sof   <= (x == '0) && (y == '0);
            pix_q.eol   <= last_x_c;
            out_valid   <= 1'b1;
            state       <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (advance_c) begin
            out_valid <= 1'b0;
            if (last_x_c && last_y_c) begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state      <= ST_ISSUE;
              calc_start <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_depth = pix_q.depth;
  assign out_x     = pix_q.x;
  assign out_y     = pix_q.y;
  assign out_sof   = pix_q.sof;
  assign out_eol   = pix_q.eol;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench: 4x2 frame with a model depth calculator, stalls, stale done and reset.
module tb_pixel_dispatcher;

  localparam int unsigned WL   = 64;
  localparam int unsigned HR   = 4;
  localparam int unsigned VR   = 2;
  localparam int          NPIX = 8;

  localparam logic [63:0] ONE  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] HALF = 64'h0800_0000_0000_0000;
  localparam logic [63:0] RE0  = 64'hE000_0000_0000_0000;
  localparam logic [63:0] IM0  = ONE;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [WL-1:0] re_origin;
  logic [WL-1:0] im_origin;
  logic [WL-1:0] step;
  logic          calc_start;
  logic [WL-1:0] re_c;
  logic [WL-1:0] im_c;
  logic          calc_done = 1'b0;
  logic [9:0]    calc_depth = '0;
  logic          out_valid;
  logic          out_ready;
  logic [9:0]    out_depth;
  logic [10:0]   out_x;
  logic [10:0]   out_y;
  logic          out_sof;
  logic          out_eol;
  logic          busy;
  logic          frame_done;

  pixel_dispatcher #(
    .WORD_LENGTH(WL),
    .FRAC       (60),
    .H_RES      (HR),
    .V_RES      (VR)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .frame_start(frame_start),
    .re_origin  (re_origin),
    .im_origin  (im_origin),
    .step       (step),
    .calc_start (calc_start),
    .re_c       (re_c),
    .im_c       (im_c),
    .calc_done  (calc_done),
    .calc_depth (calc_depth),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_depth  (out_depth),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int          x;
    int          y;
    int          stall;
    int          stale;
    bit          midstart;
    logic [9:0]  depth;
    bit          sof;
    bit          eol;
    logic [63:0] re;
    logic [63:0] im;
  } vec_t;

  vec_t tbl[NPIX];
  vec_t sb[$];

  int total = 0;
  int bad   = 0;
  int stale_hold = 0;
  int hold_cnt = 0;
  int lat_cnt = 0;
  int n_frame_done = 0;
  logic [9:0] pend_depth = '0;
  logic signed [63:0] dx;
  logic signed [63:0] dy;

  // Depth calculator model: derives (x,y) from the coordinates it is handed,
  // answers depth=x+4y three cycles later, optionally holding the old done level.
  always @(negedge sysclk) begin
    if (frame_done) n_frame_done++;
    if (calc_start) begin
      dx = $signed(re_c - RE0) >>> 59;
      dy = $signed(IM0 - im_c) >>> 59;
      pend_depth = 10'(dx + dy * 4);
      hold_cnt = stale_hold;
      lat_cnt = 3;
      if (hold_cnt == 0) calc_done = 1'b0;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) calc_done = 1'b0;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        calc_done = 1'b1;
        calc_depth = pend_depth;
      end
    end
  end

  task automatic finish_tb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
    finish_tb();
  endtask

  task automatic check_pix(input vec_t e, input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_depth"}, 64'(out_depth), 64'(e.depth));
    chk({tag, "_x"},     64'(out_x),     64'(e.x));
    chk({tag, "_y"},     64'(out_y),     64'(e.y));
    chk({tag, "_sof"},   64'(out_sof),   64'(e.sof));
    chk({tag, "_eol"},   64'(out_eol),   64'(e.eol));
  endtask

  task automatic start_frame();
    stale_hold  = tbl[0].stale;
    re_origin   = RE0;
    im_origin   = IM0;
    step        = HALF;
    frame_start = 1'b1;
    @(negedge sysclk);
    frame_start = 1'b0;
    re_origin   = 64'h0123_4567_89AB_CDEF;
    im_origin   = 64'hFEDC_BA98_7654_3210;
    step        = ONE;
  endtask

  task automatic run_frame(input int stop_at);
    vec_t e;
    int   n;
    for (int i = 0; i < NPIX; i++) begin
      out_ready = (tbl[i].stall == 0);
      n = 0;
      while (!calc_start) begin
        if (n == 60) expire("calc_start_wait");
        @(negedge sysclk);
        n++;
      end
      chk("re_c", re_c, tbl[i].re);
      chk("im_c", im_c, tbl[i].im);
      sb.push_back(tbl[i]);

      if (i == stop_at) begin
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_calc_start", 64'(calc_start), 64'(0));
        sb.delete();
        repeat (8) @(negedge sysclk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_valid", 64'(out_valid), 64'(0));
        chk("idle_calc_start", 64'(calc_start), 64'(0));
        return;
      end

      if (tbl[i].midstart) begin
        re_origin   = ONE;
        im_origin   = ONE;
        step        = ONE;
        frame_start = 1'b1;
        @(negedge sysclk);
        frame_start = 1'b0;
      end

      n = 0;
      while (!out_valid) begin
        if (n == 60) expire("out_valid_wait");
        @(negedge sysclk);
        n++;
      end
      e = sb[0];
      for (int k = 0; k < tbl[i].stall; k++) begin
        check_pix(e, "stall");
        chk("stall_calc_start", 64'(calc_start), 64'(0));
        @(negedge sysclk);
      end
      out_ready = 1'b1;
      check_pix(e, "accept");
      void'(sb.pop_front());
      stale_hold = (i + 1 < NPIX) ? tbl[i + 1].stale : 0;
      @(negedge sysclk);
      chk("valid_drop", 64'(out_valid), 64'(0));

      if (i == NPIX - 1) begin
        chk("frame_done", 64'(frame_done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        re_origin   = ONE;
        frame_start = 1'b1;
        @(negedge sysclk);
        frame_start = 1'b0;
        chk("start_at_done_busy", 64'(busy), 64'(0));
        chk("start_at_done_calc", 64'(calc_start), 64'(0));
        chk("frame_done_pulse", 64'(frame_done), 64'(0));
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    re_origin   = '0;
    im_origin   = '0;
    step        = '0;

    for (int i = 0; i < NPIX; i++) begin
      tbl[i].x        = i % 4;
      tbl[i].y        = i / 4;
      tbl[i].stall    = (i == 2) ? 5 : 0;
      tbl[i].stale    = (i == 5) ? 4 : 0;
      tbl[i].midstart = (i == 3);
      tbl[i].depth    = 10'(tbl[i].x + 4 * tbl[i].y);
      tbl[i].sof      = (i == 0);
      tbl[i].eol      = (tbl[i].x == 3);
      tbl[i].re       = RE0;
      for (int k = 0; k < tbl[i].x; k++) tbl[i].re = tbl[i].re + HALF;
      tbl[i].im       = IM0;
      for (int k = 0; k < tbl[i].y; k++) tbl[i].im = tbl[i].im - HALF;
    end

    repeat (3) @(negedge sysclk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_calc_start", 64'(calc_start), 64'(0));
    chk("reset_frame_done", 64'(frame_done), 64'(0));
    chk("reset_out_x", 64'(out_x), 64'(0));
    chk("reset_out_y", 64'(out_y), 64'(0));
    chk("reset_depth", 64'(out_depth), 64'(0));
    chk("reset_sof", 64'(out_sof), 64'(0));
    chk("reset_eol", 64'(out_eol), 64'(0));
    chk("reset_re_c", re_c, 64'(0));
    chk("reset_im_c", im_c, 64'(0));
    reset = 1'b0;
    @(negedge sysclk);
    chk("idle_no_start", 64'(busy), 64'(0));

    start_frame();
    run_frame(NPIX);
    chk("frame_done_count1", 64'(n_frame_done), 64'(1));

    start_frame();
    run_frame(6);

    start_frame();
    run_frame(NPIX);
    chk("frame_done_count2", 64'(n_frame_done), 64'(2));

    finish_tb();
  end

endmodule
